// File: rtl/alu_pkg.sv
// Shared opcode and flag-index constants for the pipelined ALU.
// Optional feature macro: ALU_ACC_EN (accumulator opcode 110).
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_ACC = 3'b110;
  localparam logic [2:0] OP_INV = 3'b111;

  // flags bus is {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/pipelined_alu_core.sv
// Combinational ALU datapath: opcode, operands (and acc) -> result and {N,Z,C,V}.
// Macro ALU_ACC_EN adds the acc input and the ACC opcode; otherwise 110 decodes as invalid.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ALU_ACC_EN
  input  logic [WIDTH-1:0] acc,
`endif
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] res;
  logic             c_bit;
  logic             v_bit;

  always_comb begin
    ext   = '0;
    res   = '0;
    c_bit = 1'b0;
    v_bit = 1'b0;
    case (sel)
      OP_ADD: begin
        ext   = {1'b0, a} + {1'b0, b};
        res   = ext[MSB:0];
        c_bit = ext[WIDTH];
        v_bit = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        // the extra bit of the widened difference is the unsigned borrow
        ext   = {1'b0, a} - {1'b0, b};
        res   = ext[MSB:0];
        c_bit = ext[WIDTH];
        v_bit = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_NOT: res = ~a;
      OP_XOR: res = a ^ b;
`ifdef ALU_ACC_EN
      OP_ACC: begin
        ext   = {1'b0, acc} + {1'b0, a};
        res   = ext[MSB:0];
        c_bit = ext[WIDTH];
        v_bit = (acc[MSB] == a[MSB]) && (res[MSB] != acc[MSB]);
      end
`endif
      default: res = '0;
    endcase
  end

  assign result        = res;
  assign flags[FLAG_N] = res[MSB];
  assign flags[FLAG_Z] = (res == '0);
  assign flags[FLAG_C] = c_bit;
  assign flags[FLAG_V] = v_bit;

endmodule

// File: rtl/pipelined_alu.sv
// Two-stage valid/ready ALU pipeline: S1 registers the operand beat, S2 registers result/flags.
// Macro ALU_ACC_EN enables the accumulator register and ACC opcode.
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_sel_q, s1_sel_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH-1:0] core_result;
  logic [3:0]       core_flags;
  logic             advance;

  // Single global enable: the whole pipe moves or the whole pipe holds.
  assign advance  = !s2_valid_q || out_ready;
  assign in_ready = advance;

`ifdef ALU_ACC_EN
  logic [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (advance && s1_valid_q && (s1_sel_q == OP_ACC)) begin
      acc_d = core_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  alu_core #(.WIDTH(WIDTH)) u_core (
    .sel    (s1_sel_q),
    .a      (s1_a_q),
    .b      (s1_b_q),
`ifdef ALU_ACC_EN
    .acc    (acc_q),
`endif
    .result (core_result),
    .flags  (core_flags)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_sel_d   = s1_sel_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    flags_d    = flags_q;
    if (advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d   = a;
        s1_b_d   = b;
        s1_sel_d = sel;
      end
      s2_valid_d = s1_valid_q;
      // an empty S1 leaves the old result in place; out_valid marks it stale
      if (s1_valid_q) begin
        result_d = core_result;
        flags_d  = core_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sel_q   <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_sel_q   <= s1_sel_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu (WIDTH=8): directed scenarios plus random traffic
// against an arithmetic reference model and an in-order scoreboard.
module tb_pipelined_alu;

  localparam int    W    = 8;
  localparam longint MOD  = 256;
  localparam longint HALF = 128;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   flg;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  int     n_checks = 0;
  int     n_errors = 0;
  exp_t   sb_q[$];
  longint model_acc = 0;

  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_res;
  logic [3:0]   prev_flg;
  exp_t         got_e;

  always #5 clk = ~clk;

  pipelined_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint to_signed(input longint u);
    return (u >= HALF) ? u - MOD : u;
  endfunction

  // Reference: plain integer arithmetic on the opcode table; updates model_acc for ACC.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t   e;
    longint ua = longint'(av);
    longint ub = longint'(bv);
    longint full;
    longint sr;
    longint r = 0;
    logic   c = 1'b0;
    logic   v = 1'b0;
    case (op)
      3'd0: begin
        full = ua + ub;
        r = full % MOD; c = (full >= MOD);
        sr = to_signed(ua) + to_signed(ub); v = (sr >= HALF) || (sr < -HALF);
      end
      3'd1: begin
        full = ua - ub;
        r = (full + MOD) % MOD; c = (ua < ub);
        sr = to_signed(ua) - to_signed(ub); v = (sr >= HALF) || (sr < -HALF);
      end
      3'd2: r = longint'(av & bv);
      3'd3: r = longint'(av | bv);
      3'd4: r = (MOD - 1) - ua;
      3'd5: r = longint'(av ^ bv);
`ifdef ALU_ACC_EN
      3'd6: begin
        full = model_acc + ua;
        r = full % MOD; c = (full >= MOD);
        sr = to_signed(model_acc) + to_signed(ua); v = (sr >= HALF) || (sr < -HALF);
        model_acc = r;
      end
`endif
      default: r = 0;
    endcase
    e.res = r[W-1:0];
    e.flg = {(r >= HALF), (r == 0), c, v};
    return e;
  endfunction

  // Monitor/scoreboard: everything sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      model_acc = 0;
      prev_stall = 1'b0;
    end else begin
      check_val("in_ready", in_ready, !out_valid || out_ready);
      if (prev_stall && out_valid) begin
        check_val("hold_result", result, prev_res);
        check_val("hold_flags", flags, prev_flg);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_out", 1, 0);
        end else begin
          got_e = sb_q.pop_front();
          check_val("result", result, got_e.res);
          check_val("flags", flags, got_e.flg);
          $display("out result=%02h flags=%04b exp=%02h/%04b", result, flags, got_e.res, got_e.flg);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(sel, a, b));
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
      prev_flg   = flags;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat (entered just after a rising edge) and return just after its accept edge.
  task automatic send(input logic [2:0] s, input logic [W-1:0] av, input logic [W-1:0] bv);
    int n = 0;
    in_valid = 1'b1; sel = s; a = av; b = bv;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check_val("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_result", result, 0);
    check_val("rst_flags", flags, 0);
    check_val("rst_in_ready", in_ready, 1);

    // first beat: 3+1 with explicit latency check
    sync();
    in_valid = 1'b1; a = 8'd3; b = 8'd1; sel = 3'b000;
    sync();
    in_valid = 1'b0;
    @(negedge clk);
    check_val("lat_cycle1", out_valid, 0);
    @(negedge clk);
    check_val("lat_cycle2", out_valid, 1);
    check_val("first_result", result, 8'd4);
    check_val("first_flags", flags, 4'b0000);

    // corner arithmetic and logic stream
    sync();
    send(3'b001, 8'h00, 8'h01);
    send(3'b000, 8'h7F, 8'h01);
    send(3'b010, 8'hCC, 8'hAA);
    send(3'b011, 8'hCC, 8'hAA);
    send(3'b100, 8'hCC, 8'hAA);
    send(3'b111, 8'hCC, 8'hAA);

    // stall with two beats in flight
    send(3'b000, 8'h10, 8'h20);
    send(3'b101, 8'h0F, 8'hFF);
    out_ready = 1'b0;
    repeat (5) sync();
    out_ready = 1'b1;
    repeat (3) sync();

`ifdef ALU_ACC_EN
    send(3'b110, 8'd5, 8'($urandom));
    send(3'b110, 8'd10, 8'($urandom));
    out_ready = 1'b0;
    repeat (3) sync();
    out_ready = 1'b1;
    send(3'b110, 8'd250, 8'($urandom));
    repeat (3) sync();
`endif

    // reset with beats in S1 and S2
    send(3'b000, 8'd1, 8'd2);
    send(3'b001, 8'd5, 8'd3);
    rst = 1'b1; in_valid = 1'b1; sel = 3'b000; a = 8'd9; b = 8'd9;
    sync();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_in_ready", in_ready, 1);
    repeat (4) sync();
`ifdef ALU_ACC_EN
    send(3'b110, 8'd7, 8'd0);
    repeat (3) sync();
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      sel       = 3'($urandom % 8);
      a         = 8'($urandom);
      b         = 8'($urandom);
      sync();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    check_val("drain_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
